// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between the fetch port and the load/store port.
// Define ARB_FAIRNESS_EN to bound how many data grants can starve a waiting fetch.
module unified_mem_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_ready,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ack,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, BUS_I, BUS_D, DONE} state_e;

    if (MAX_D_STREAK < 1) begin : g_bad_cfg
        $error("MAX_D_STREAK must be at least 1");
    end

    state_e        state_q, state_d;
    logic          m_req_q, m_req_d, m_we_q, m_we_d;
    logic [AW-1:0] m_addr_q, m_addr_d;
    logic [DW-1:0] m_wdata_q, m_wdata_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic          i_ready_q, i_ready_d, d_ready_q, d_ready_d;
    logic          grant_d, grant_i;

`ifdef ARB_FAIRNESS_EN
    localparam int unsigned CW = $clog2(MAX_D_STREAK + 1);
    logic [CW-1:0] streak_q, streak_d;

    // A full streak with fetch waiting hands the next IDLE grant to fetch.
    assign grant_d = d_req && !(i_req && (streak_q == CW'(MAX_D_STREAK)));
    assign grant_i = i_req && !grant_d;

    always_comb begin
        streak_d = streak_q;
        if (state_q == IDLE) begin
            if (grant_i) begin
                streak_d = '0;
            end else if (grant_d) begin
                if (!i_req)
                    streak_d = '0;
                else if (streak_q != CW'(MAX_D_STREAK))
                    streak_d = streak_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) streak_q <= '0;
        else     streak_q <= streak_d;
    end
`else
    assign grant_d = d_req;
    assign grant_i = i_req && !d_req;
`endif

    // State register, including all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_ready_q <= i_ready_d;
            d_ready_q <= d_ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (grant_d)      state_d = BUS_D;
                else if (grant_i) state_d = BUS_I;
            end
            BUS_I, BUS_D: if (m_ack) state_d = DONE;
            DONE:         state_d = IDLE;
            default:      state_d = IDLE;
        endcase
    end

    always_comb begin
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_ready_d = 1'b0;
        d_ready_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant_d) begin
                    m_req_d   = 1'b1;
                    m_we_d    = d_we;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                end else if (grant_i) begin
                    m_req_d  = 1'b1;
                    m_we_d   = 1'b0;
                    m_addr_d = i_addr;
                end
            end
            BUS_I: begin
                if (m_ack) begin
                    m_req_d   = 1'b0;
                    m_we_d    = 1'b0;
                    i_ready_d = 1'b1;
                    i_rdata_d = m_rdata;
                end
            end
            BUS_D: begin
                if (m_ack) begin
                    m_req_d   = 1'b0;
                    m_we_d    = 1'b0;
                    d_ready_d = 1'b1;
                    if (!m_we_q) d_rdata_d = m_rdata;
                end
            end
            default: ;
        endcase
    end

    assign m_req   = m_req_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign i_ready = i_ready_q;
    assign d_ready = d_ready_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Arbitrates one shared single-port memory between the instruction-fetch port (IF stage) and the data port (MEM stage lw/sw) of the 5-stage MIPS pipeline.
- Lets the split inst_mem/data memory be replaced by one unified memory with variable-latency req/ack timing.
- The pipeline stalls a stage while its req is high and its ready has not pulsed.

Parameters:
- AW, 32, address width (byte address).
- DW, 32, data width.
- MAX_D_STREAK, 4, consecutive data grants allowed while i_req waits. Used only with ARB_FAIRNESS_EN.

Ports:
clk  in  1  clock
rst  in  1  reset
i_req  in  1  fetch request, held until i_ready
i_addr  in  AW  fetch byte address
i_rdata  out  DW  fetched word, valid from i_ready, held until next fetch completes
i_ready  out  1  one-cycle completion pulse for fetch
d_req  in  1  data request, held until d_ready
d_we  in  1  1 = store (sw), 0 = load (lw)
d_addr  in  AW  data byte address
d_wdata  in  DW  store data
d_rdata  out  DW  load data, valid from d_ready, held until next load completes
d_ready  out  1  one-cycle completion pulse for data
m_req  out  1  memory request
m_we  out  1  memory write enable, only high while m_req is high
m_addr  out  AW  memory address
m_wdata  out  DW  memory write data
m_rdata  in  DW  memory read data, valid when m_ack is high
m_ack  in  1  memory completion, sampled while m_req is high
busy  out  1  high when state is not IDLE

Behaviour:
- Reset: rst asynchronous, active-high; clock clk. Reset is asynchronous and forces:
  - state IDLE;
  - m_req, m_we, i_ready, d_ready = 0;
  - m_addr, m_wdata, i_rdata, d_rdata = 0;
  - streak counter = 0.
- All outputs are registered, except busy, which is decoded from state.
- States: IDLE, BUS_I, BUS_D, DONE.
- IDLE, selection at each clock edge:
  - d_req=1: latch d_addr, d_we, d_wdata into m_addr, m_we, m_wdata; set m_req=1; go to BUS_D.
  - else i_req=1: latch i_addr into m_addr; m_we=0; m_wdata unchanged; m_req=1; go to BUS_I.
  - else: stay in IDLE.
  - Data has fixed priority over fetch, because the MEM-stage instruction is older.
- BUS_I / BUS_D:
  - m_req, m_we, m_addr, m_wdata are held stable until an edge samples m_ack=1.
  - At that edge: m_req=0, m_we=0; owner's ready=1; go to DONE.
  - Read data capture at that edge: BUS_I captures m_rdata into i_rdata. BUS_D with m_we=0 captures m_rdata into d_rdata. A store leaves d_rdata unchanged.
- DONE:
  - The ready pulse lasts exactly this one cycle; the next edge clears it and returns to IDLE.
  - Requests are ignored in DONE, so a requester still holding req in the ready cycle is not served twice.
- Latency:
  - Request seen at edge N gives m_req high from cycle N+1.
  - m_ack sampled at edge K gives ready high in cycle K+1.
  - Minimum 3 cycles per transaction with m_ack tied high. Back-to-back issue rate is one per 3 cycles.
- Inputs are sampled only at grant:
  - Changing address or data after grant has no effect.
  - Dropping req after grant does not abort: the transaction completes and ready still pulses.
- m_ack outside BUS_I/BUS_D is ignored.
- Reset mid-transaction: the in-flight access is abandoned with m_req dropped immediately and no ready pulse afterwards. The memory must tolerate m_req falling without ack.
- Address arithmetic: m_addr is a byte address passed through unmodified. Word alignment is the memory's responsibility.

Optional Feature:
ARB_FAIRNESS_EN:
- Defined:
  - A counter, saturating at MAX_D_STREAK, increments on each data grant made while i_req=1.
  - When the counter equals MAX_D_STREAK and both requests are pending in IDLE, fetch is granted instead.
  - The counter clears on every fetch grant and whenever i_req=0 at a grant.
- Undefined: strict data priority, no counter logic.

Test Plan:
- Fetch only: i_req=1, i_addr=0x4; memory acks 2 cycles after m_req with m_rdata=0x20090000 -> m_req rises the cycle after i_req, m_we=0, m_addr=0x4, i_ready high 1 cycle after ack, i_rdata=0x20090000, busy low after DONE.
- Collision: i_req and d_req rise together, d_addr=0x8, d_we=0, m_ack tied 1, m_rdata=0x8 -> data served first, d_ready then d_rdata=0x8; fetch granted in the IDLE cycle after DONE; i_ready 3 cycles after d_ready.
- Store: d_we=1, d_addr=0x0, d_wdata=0x5 -> m_we=1, m_wdata=0x5 held until ack, d_ready pulses, d_rdata keeps previous value 0x8.
- Zero-wait streaming: m_ack tied 1, i_req held for 4 fetches at 0x0, 0x4, 0x8, 0xC -> i_ready every 3rd cycle, never 2 cycles in a row, each address issued exactly once.
- Reset mid-access: assert rst in BUS_D with m_ack=0 -> m_req, m_we, ready and data outputs 0 asynchronously; after release, no d_ready occurs without a new grant.
- Fairness: d_req and i_req held high, m_ack tied 1 -> with ARB_FAIRNESS_EN, the 5th grant is fetch. Without it, there are no fetch grants across 10 data transactions.
